// File: rtl/ifetch_pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pc_ctrl_pkg
// Description : Shared CPU fetch constants: reset PC default, fetch-control
//               state encodings, word-alignment mask and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pc_ctrl_pkg;

  // PC loaded on reset unless the top overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Clears the byte-offset bits of a target so fetches stay word aligned
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Saturation ceiling of the taken-branch counter
  localparam logic [15:0] TAKEN_COUNT_MAX = 16'hFFFF;

  // Normal fetch vs. waiting out a stall with a branch target on hold
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  // Word-align a redirect target
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return target & ALIGN_MASK;
  endfunction

  // A target is misaligned when any byte-offset bit is set
  function automatic logic is_misaligned(input logic [1:0] offset);
    return offset != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pc_ctrl_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational branch resolution. Combines the registered
//               branch-type flags with the rs condition flags (zero,
//               positive, negative) into a single taken decision.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond (
  input  logic zero,
  input  logic positive,
  input  logic negative,
  input  logic beq,
  input  logic bne,
  input  logic bgez,
  input  logic bgtz,
  input  logic bltz,
  input  logic blez,
  input  logic bgezal,
  input  logic bltzal,
  output logic taken
);

  // Each branch type is qualified by the rs relation it tests against zero
  always_comb begin
    taken = (beq    &  zero)
          | (bne    & ~zero)
          | (bgez   & (positive | zero))
          | (bgtz   &  positive)
          | (bltz   &  negative)
          | (blez   & (negative | zero))
          | (bgezal & (positive | zero))
          | (bltzal &  negative);
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pc_ctrl
// Description : Instruction-fetch PC controller. Sequences the fetch address
//               (PC+4, jump redirect, branch redirect), holds a taken branch
//               target across hazard stalls, raises pipeline flushes, flags
//               misaligned targets and counts taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_pc_ctrl
  import ifetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IF_Zero,
  input  logic        IF_Positive,
  input  logic        IF_Negative,
  input  logic        IF_Beq,
  input  logic        IF_Bne,
  input  logic        IF_Bgez,
  input  logic        IF_Bgtz,
  input  logic        IF_Bltz,
  input  logic        IF_Blez,
  input  logic        IF_Bgezal,
  input  logic        IF_Bltzal,
  input  logic [31:0] IF_Branch_PC,
  input  logic        ID_Jump,
  input  logic [31:0] ID_Jump_PC,
  input  logic        PC_Stall,
  output logic [31:0] PC,
  output logic        Branch_Taken,
  output logic        Flush_Branch,
  output logic        Flush_IF_ID,
  output logic        Addr_Error,
  output logic [15:0] Taken_Count
);

  pc_state_e   state;
  pc_state_e   state_next;
  logic [31:0] pend_target;
  logic [31:0] pend_target_next;
  logic [31:0] pc_next;
  logic        addr_error_next;
  logic        count_inc;
  logic        cond_taken;

  branch_cond u_branch_cond (
    .zero     (IF_Zero),
    .positive (IF_Positive),
    .negative (IF_Negative),
    .beq      (IF_Beq),
    .bne      (IF_Bne),
    .bgez     (IF_Bgez),
    .bgtz     (IF_Bgtz),
    .bltz     (IF_Bltz),
    .blez     (IF_Blez),
    .bgezal   (IF_Bgezal),
    .bltzal   (IF_Bltzal),
    .taken    (cond_taken)
  );

  // Fetch-control state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next PC, next state, flushes and error flag; while PEND the flags in
  // EX/MEM and ID belong to flushed younger instructions and are ignored
  always_comb begin
    state_next       = state;
    pc_next          = PC;
    pend_target_next = pend_target;
    addr_error_next  = 1'b0;
    count_inc        = 1'b0;
    Branch_Taken     = 1'b0;
    Flush_Branch     = 1'b0;
    Flush_IF_ID      = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (cond_taken) begin
            // Branch beats a same-cycle jump; the jump is younger and flushed
            Branch_Taken = 1'b1;
            Flush_Branch = 1'b1;
            count_inc    = 1'b1;
            if (PC_Stall) begin
              pend_target_next = IF_Branch_PC;
              state_next       = PEND;
            end else begin
              pc_next         = align_pc(IF_Branch_PC);
              addr_error_next = is_misaligned(IF_Branch_PC[1:0]);
            end
          end else if (ID_Jump && !PC_Stall) begin
            // A stalled jump is re-presented by ID, so no flush until it goes
            Flush_IF_ID     = 1'b1;
            pc_next         = align_pc(ID_Jump_PC);
            addr_error_next = is_misaligned(ID_Jump_PC[1:0]);
          end else if (!PC_Stall) begin
            pc_next = PC + 32'd4;
          end
        end
        PEND: begin
          if (!PC_Stall) begin
            pc_next         = align_pc(pend_target);
            addr_error_next = is_misaligned(pend_target[1:0]);
            state_next      = RUN;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // PC, held branch target and misalignment pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PC          <= RESET_PC;
      pend_target <= 32'h0000_0000;
      Addr_Error  <= 1'b0;
    end else begin
      PC          <= pc_next;
      pend_target <= pend_target_next;
      Addr_Error  <= addr_error_next;
    end
  end

  // Saturating taken-branch counter; applying a held target is not a new branch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Taken_Count <= 16'h0000;
    end else if (count_inc && (Taken_Count != TAKEN_COUNT_MAX)) begin
      Taken_Count <= Taken_Count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_pc_ctrl
// Description : Scoreboard bench for ifetch_pc_ctrl. A driver issues one
//               stimulus per cycle and pushes the expected outputs from a
//               behavioural model; a monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NONE     = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        IF_Zero, IF_Positive, IF_Negative;
  logic        IF_Beq, IF_Bne, IF_Bgez, IF_Bgtz, IF_Bltz, IF_Blez, IF_Bgezal, IF_Bltzal;
  logic [31:0] IF_Branch_PC;
  logic        ID_Jump;
  logic [31:0] ID_Jump_PC;
  logic        PC_Stall;
  logic [31:0] PC;
  logic        Branch_Taken, Flush_Branch, Flush_IF_ID, Addr_Error;
  logic [15:0] Taken_Count;

  ifetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .reset        (reset),
    .IF_Zero      (IF_Zero),
    .IF_Positive  (IF_Positive),
    .IF_Negative  (IF_Negative),
    .IF_Beq       (IF_Beq),
    .IF_Bne       (IF_Bne),
    .IF_Bgez      (IF_Bgez),
    .IF_Bgtz      (IF_Bgtz),
    .IF_Bltz      (IF_Bltz),
    .IF_Blez      (IF_Blez),
    .IF_Bgezal    (IF_Bgezal),
    .IF_Bltzal    (IF_Bltzal),
    .IF_Branch_PC (IF_Branch_PC),
    .ID_Jump      (ID_Jump),
    .ID_Jump_PC   (ID_Jump_PC),
    .PC_Stall     (PC_Stall),
    .PC           (PC),
    .Branch_Taken (Branch_Taken),
    .Flush_Branch (Flush_Branch),
    .Flush_IF_ID  (Flush_IF_ID),
    .Addr_Error   (Addr_Error),
    .Taken_Count  (Taken_Count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        bt;
    logic        fb;
    logic        fj;
    logic        ae;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: architectural view of the fetch unit
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_target;
  int          m_cnt;
  bit          m_ae;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Branch decision from the signed rs value, the way the ISA defines it
  function automatic bit branch_cond_ref(input int btype, input int rs);
    case (btype)
      0: return rs == 0;
      1: return rs != 0;
      2: return rs >= 0;
      3: return rs > 0;
      4: return rs < 0;
      5: return rs <= 0;
      6: return rs >= 0;
      7: return rs < 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_pend   = 0;
    m_target = 32'h0;
    m_cnt    = 0;
    m_ae     = 0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.pc = RESET_PC; e.bt = 0; e.fb = 0; e.fj = 0; e.ae = 0; e.cnt = 16'h0;
    q.push_back(e);
  endtask

  task automatic drive(input logic rst_v, input int btype, input int rs,
                       input logic [31:0] bpc, input logic jmp,
                       input logic [31:0] jpc, input logic stall);
    reset        = rst_v;
    IF_Zero      = (rs == 0);
    IF_Positive  = (rs > 0);
    IF_Negative  = (rs < 0);
    IF_Beq       = (btype == 0);
    IF_Bne       = (btype == 1);
    IF_Bgez      = (btype == 2);
    IF_Bgtz      = (btype == 3);
    IF_Bltz      = (btype == 4);
    IF_Blez      = (btype == 5);
    IF_Bgezal    = (btype == 6);
    IF_Bltzal    = (btype == 7);
    IF_Branch_PC = bpc;
    ID_Jump      = jmp;
    ID_Jump_PC   = jpc;
    PC_Stall     = stall;
  endtask

  // One cycle of stimulus: drive, push this cycle's expectation, advance model
  task automatic step(input logic rst_v, input int btype, input int rs,
                      input logic [31:0] bpc, input logic jmp,
                      input logic [31:0] jpc, input logic stall);
    exp_t e;
    bit   tk;
    @(posedge clock);
    #2;
    drive(rst_v, btype, rs, bpc, jmp, jpc, stall);
    if (rst_v) begin
      model_reset();
      push_reset_exp();
      return;
    end
    tk    = !m_pend && branch_cond_ref(btype, rs);
    e.pc  = m_pc;
    e.bt  = tk;
    e.fb  = tk;
    e.fj  = !m_pend && !tk && jmp && !stall;
    e.ae  = m_ae;
    e.cnt = m_cnt[15:0];
    q.push_back(e);
    m_ae = 0;
    if (m_pend) begin
      if (!stall) begin
        m_pc   = m_target & ~32'h3;
        m_ae   = (m_target % 4) != 0;
        m_pend = 0;
      end
    end else if (tk) begin
      if (m_cnt < 65535) m_cnt++;
      if (stall) begin
        m_pend   = 1;
        m_target = bpc;
      end else begin
        m_pc = bpc & ~32'h3;
        m_ae = (bpc % 4) != 0;
      end
    end else if (jmp && !stall) begin
      m_pc = jpc & ~32'h3;
      m_ae = (jpc % 4) != 0;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC",           PC,           e.pc);
        chk("Branch_Taken", 32'(Branch_Taken), 32'(e.bt));
        chk("Flush_Branch", 32'(Flush_Branch), 32'(e.fb));
        chk("Flush_IF_ID",  32'(Flush_IF_ID),  32'(e.fj));
        chk("Addr_Error",   32'(Addr_Error),   32'(e.ae));
        chk("Taken_Count",  32'(Taken_Count),  32'(e.cnt));
      end
    end
  end

  initial begin
    int btype, rs, sel;
    drive(1'b1, NONE, 1, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();

    // Reset held with live branch/jump requests: outputs forced low
    step(1, 0, 0, 32'h0000_0100, 1, 32'h0000_0200, 0);
    step(1, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Sequential fetch 0,4,8,12
    for (int i = 0; i < 4; i++) step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Unstalled bne taken to 0x100
    step(0, 1, 5, 32'h0000_0100, 0, 32'h0, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Stalled beq taken to 0x200; younger flags ignored while held
    step(0, 0, 0, 32'h0000_0200, 0, 32'h0, 1);
    step(0, 1, 3, 32'h0000_0300, 1, 32'h0000_0400, 1);
    step(0, 4, -1, 32'h0000_0500, 0, 32'h0, 1);
    step(0, 1, 3, 32'h0000_0600, 1, 32'h0000_0700, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Taken bltzal beats same-cycle jump
    step(0, 7, -3, 32'h0000_0040, 1, 32'h0000_0080, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Misaligned jump target
    step(0, NONE, 1, 32'h0, 1, 32'h0000_0102, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Stalled jump is held without flush
    step(0, NONE, 1, 32'h0, 1, 32'h0000_0800, 1);
    // PC wrap at top of address space
    step(0, NONE, 1, 32'h0, 1, 32'hFFFF_FFFC, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    // Enter PEND then assert reset asynchronously mid-cycle
    step(0, 3, 9, 32'h0000_0A00, 0, 32'h0, 1);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 1);
    @(posedge clock);
    #2;
    drive(1'b1, 0, 0, 32'h0000_0B00, 1, 32'h0000_0C00, 1);
    #1;
    chk("async_reset_PC", PC, RESET_PC);
    chk("async_reset_count", 32'(Taken_Count), 32'h0);
    model_reset();
    push_reset_exp();
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);

    // Randomized traffic including occasional resets and misaligned targets
    for (int i = 0; i < 600; i++) begin
      sel   = $urandom_range(0, 99);
      btype = $urandom_range(0, 11);
      rs    = $urandom_range(0, 2) - 1;
      step(sel < 2, btype, rs, $urandom, ($urandom_range(0, 4) == 0),
           $urandom, ($urandom_range(0, 9) < 3));
    end

    // Drive the counter through saturation
    for (int i = 0; i < 65600; i++) begin
      step(0, 1, 2, {$urandom_range(0, 255), 2'b00}, 0, 32'h0, 0);
    end
    step(0, NONE, 1, 32'h0, 0, 32'h0, 0);

    @(posedge clock);
    @(negedge clock);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_pc_ctrl.md
IFETCH_PC_CTRL -- requirements
Module: ifetch_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-high (ports named clock and reset).
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 IF_Zero, IF_Positive, IF_Negative  in  1 each  registered condition flags from EX/MEM (rs==0, rs>0, rs<0).
REQ-006 IF_Beq, IF_Bne, IF_Bgez, IF_Bgtz, IF_Bltz, IF_Blez, IF_Bgezal, IF_Bltzal  in  1 each  registered branch-type flags from EX/MEM.
REQ-007 IF_Branch_PC  in  32  branch target from EX/MEM.
REQ-008 ID_Jump  in  1  j/jal/jr decoded in ID this cycle.
REQ-009 ID_Jump_PC  in  32  jump target from ID.
REQ-010 PC_Stall  in  1  hazard unit hold request.
REQ-011 PC  out  32  current fetch address (registered).
REQ-012 Branch_Taken  out  1  combinational: resolved branch taken this cycle.
REQ-013 Flush_Branch  out  1  combinational: flush IF/ID, ID/EX and EX/MEM.
REQ-014 Flush_IF_ID  out  1  combinational: flush IF/ID only (jump redirect).
REQ-015 Addr_Error  out  1  registered one-cycle pulse: applied target had bits [1:0] != 0.
REQ-016 Taken_Count  out  16  saturating count of taken branches.

Function
REQ-017 Taken SHALL equal Beq&Z | Bne&~Z | Bgez&(P|Z) | Bgtz&P | Bltz&N | Blez&(N|Z) | Bgezal&(P|Z) | Bltzal&N.
REQ-018 State machine SHALL have states RUN and PEND; reset enters RUN.
REQ-019 RUN, taken, ~PC_Stall: PC <= {IF_Branch_PC[31:2],2'b00} at next edge; Flush_Branch=1 same cycle; stay RUN.
REQ-020 RUN, taken, PC_Stall: target latched into pending register; Flush_Branch=1 same cycle; PC held; go PEND.
REQ-021 PEND: PC held while PC_Stall=1; first cycle PC_Stall=0, PC <= pending target, return RUN.
REQ-022 PEND: all branch flags and ID_Jump SHALL be ignored (younger, flushed); Branch_Taken=0, Flush outputs=0.
REQ-023 RUN, not taken, ID_Jump, ~PC_Stall: PC <= {ID_Jump_PC[31:2],2'b00}; Flush_IF_ID=1 same cycle.
REQ-024 Taken branch and ID_Jump same cycle: branch wins, jump dropped, Flush_IF_ID=0.
REQ-025 ID_Jump with PC_Stall=1: PC held, no flush (ID re-presents jump next cycle).
REQ-026 Otherwise RUN, ~PC_Stall: PC <= PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); PC_Stall=1: PC held.
REQ-027 Addr_Error SHALL pulse one cycle after the edge that applies a target whose raw bits [1:0] != 0.
REQ-028 Taken_Count SHALL increment once per taken branch (REQ-019/020, not on PEND apply) and saturate at 16'hFFFF.
REQ-029 Redirect latency: one edge from the taken cycle (unstalled); flush is zero-latency combinational.

Reset
REQ-030 On reset assertion, asynchronously: PC=RESET_PC, state=RUN, pending target=0, Addr_Error=0, Taken_Count=0.
REQ-031 While reset=1, Branch_Taken, Flush_Branch and Flush_IF_ID SHALL be forced 0.
REQ-032 Reset mid-PEND SHALL discard the pending target; first fetch after release is RESET_PC.

Structure
REQ-033 RESET_PC default, RUN/PEND encodings and ALIGN mask SHALL live in the shared CPU constants package/header.
REQ-034 Condition evaluation (REQ-017) SHALL be one combinational sub-module branch_cond; PC/FSM/counter in the top.

Verification
REQ-035 Reset, no stall, 4 cycles -> PC 0,4,8,12; outputs 0.
REQ-036 IF_Bne=1, IF_Zero=0, IF_Branch_PC=32'h0000_0100 -> Branch_Taken=1, Flush_Branch=1 that cycle; next PC=32'h100; Taken_Count=1.
REQ-037 IF_Beq=1, IF_Zero=1, PC_Stall=1 for 3 cycles, target 32'h200 -> PC held 3 cycles, then 32'h200; Taken_Count=1.
REQ-038 Taken IF_Bltzal (N=1, target 32'h40) with ID_Jump=1, ID_Jump_PC=32'h80 -> PC=32'h40, Flush_IF_ID=0.
REQ-039 ID_Jump=1, ID_Jump_PC=32'h0000_0102 -> PC=32'h100, Flush_IF_ID=1, Addr_Error pulses once.
REQ-040 PC=32'hFFFF_FFFC, no stall -> PC=0; reset asserted during PEND -> PC=RESET_PC immediately.
